// File: rtl/qam_demod.sv
// 16-QAM hard-decision demapper. It gates symbols on carrier presence, slices each
// symbol into four bits and queues them as 2-bit codewords behind a valid/ready FIFO.
module qam_demod #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 3
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       sym_valid,
  input  logic [3:0] I_in,
  input  logic [3:0] Q_in,
  output logic [1:0] cw_out,
  output logic       cw_valid,
  input  logic       cw_ready,
  output logic       carrier,
  output logic       overflow,
  output logic [7:0] unrel_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int ZW = $clog2(GAP + 1);

  typedef enum logic {IDLE = 1'b0, TRACK = 1'b1} state_t;

  state_t        state;
  logic [ZW-1:0] zcnt;
  logic          s1_valid;
  logic [3:0]    s1_bits;
  logic          s1_unrel;

  logic [1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          is_zero;
  logic          gap_hit;
  logic          accept;
  logic [3:0]    bits;
  logic          unrel;
  logic          pop;
  logic          push;
  logic [CW:0]   free;

  function automatic logic [1:0] slice(input logic signed [3:0] v);
    return {~v[3], (v > -4'sd4) && (v < 4'sd4)};
  endfunction

  function automatic logic on_threshold(input logic signed [3:0] v);
    return (v == -4'sd4) || (v == 4'sd0) || (v == 4'sd4);
  endfunction

  always_comb begin
    is_zero = (I_in == '0) && (Q_in == '0);
    gap_hit = is_zero && (zcnt == ZW'(GAP - 1));
    accept  = '0;
    if (sym_valid)
      accept = (state == IDLE) ? !is_zero : !gap_hit;
    bits  = {slice(I_in), slice(Q_in)};
    unrel = on_threshold(I_in) || on_threshold(Q_in);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      carrier  <= '0;
      zcnt     <= '0;
      s1_valid <= '0;
      s1_bits  <= '0;
      s1_unrel <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_bits  <= bits;
        s1_unrel <= unrel;
      end
      if (sym_valid) begin
        case (state)
          IDLE: begin
            if (!is_zero) begin
              state   <= TRACK;
              carrier <= 1'b1;
              zcnt    <= '0;
            end
          end
          TRACK: begin
            if (!is_zero) begin
              zcnt <= '0;
            end else if (gap_hit) begin
              zcnt    <= ZW'(GAP);
              state   <= IDLE;
              carrier <= 1'b0;
            end else begin
              zcnt <= zcnt + ZW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // A pop on the same edge frees a slot, so it counts toward room for the pair.
  always_comb begin
    pop  = cw_valid && cw_ready;
    free = (CW + 1)'(FIFO_DEPTH) - (CW + 1)'(count) + (CW + 1)'(pop);
    push = s1_valid && (free >= (CW + 1)'(2));
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= '0;
      unrel_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr]          <= s1_bits[3:2];
        mem[wr_ptr + AW'(1)] <= s1_bits[1:0];
        wr_ptr               <= wr_ptr + AW'(2);
        if (s1_unrel && (unrel_cnt != '1))
          unrel_cnt <= unrel_cnt + 8'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count    <= count + CW'(push ? 2 : 0) - CW'(pop);
      overflow <= s1_valid && !push;
    end
  end

  assign cw_valid = (count != '0);
  assign cw_out   = cw_valid ? mem[rd_ptr] : '0;

endmodule

// File: doc/qam_demod.md
# qam_demod

Receive-side 16-QAM hard-decision demapper that consumes the signed 4-bit I/Q symbols produced by the transmit channel model. It detects carrier presence and slices each symbol into four bits. It emits the bits as 2-bit codeword pairs through a small FIFO with a valid/ready handshake, so the downstream decoder can stall. It also reports overflow and a count of unreliable (on-threshold) symbols.

## Interface
- FIFO_DEPTH, 4: codeword FIFO entries (2 bits each); power of two, ≥2.
- GAP, 3: consecutive zero symbols that declare loss of carrier.
- sys_clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sym_valid  in  1  one-cycle strobe; I_in/Q_in hold a new symbol.
- I_in  in  4  signed in-phase sample.
- Q_in  in  4  signed quadrature sample.
- cw_out  out  2  codeword pair at FIFO head.
- cw_valid  out  1  FIFO non-empty.
- cw_ready  in  1  consumer accepts cw_out when cw_valid && cw_ready.
- carrier  out  1  1 = carrier present (TRACK state).
- overflow  out  1  one-cycle pulse, symbol dropped for lack of space.
- unrel_cnt  out  8  saturating count of unreliable accepted symbols.

## Operation
- Slicing, per component v (signed 4-bit):
  - hi = (v ≥ 0).
  - lo = (-4 < v < 4).
  - Resulting map: -6→00, -2→01, +2→11, +6→10.
  - Ties: -4→00, 0→11, +4→10. -8 and +7 saturate to outer levels.
- Symbol bits {b3,b2,b1,b0} = {hi_I, lo_I, hi_Q, lo_Q}.
- A symbol is unreliable if I or Q ∈ {-4, 0, +4}.
- A zero symbol is one with I_in == 0 and Q_in == 0.
- State machine, states IDLE (carrier=0) and TRACK (carrier=1):
  - IDLE: zero symbols are discarded. A nonzero symbol moves to TRACK, and that symbol is accepted.
  - TRACK: every symbol is accepted, including zero symbols. zcnt counts consecutive zero symbols, saturating at GAP, and clears on any nonzero symbol.
  - When zcnt reaches GAP: the GAP-th zero symbol is discarded and the state goes to IDLE. Earlier zero symbols were already accepted and demap to 1111.
  - Entering IDLE does not flush the FIFO; it drains normally.
- Accepted symbol handling:
  - Stage 1 (edge on which sym_valid is sampled) registers the sliced bits and the unreliable flag.
  - Stage 2 (next edge) pushes two entries: {b3,b2} first, then {b1,b0}.
- Space check at push: free = FIFO_DEPTH − count + (pop this cycle ? 1 : 0). Push only if free ≥ 2.
- On a failed space check: drop both entries, pulse overflow for one cycle, and do not change unrel_cnt.
- unrel_cnt increments on successful push of an unreliable symbol and saturates at 255.
- Pop occurs when cw_valid && cw_ready. cw_out is the head entry and is stable while cw_valid && !cw_ready.
- Pointers wrap modulo FIFO_DEPTH. count is stored with width log2(FIFO_DEPTH)+1.

## Timing
- Reset (asynchronous assert, synchronous release) clears all state:
  - state=IDLE, zcnt=0, FIFO empty, stage-1 register cleared.
  - carrier=0, cw_valid=0, cw_out=00, overflow=0, unrel_cnt=0.
- Latency: sym_valid sampled at edge t → entry pushed at edge t+1 → cw_valid=1 after edge t+1 with cw_out={b3,b2}.
  - With cw_ready held high, {b1,b0} is presented after edge t+2.
- carrier rises after the edge that samples the first nonzero symbol. It falls after the edge that samples the GAP-th consecutive zero.
- sym_valid may arrive on back-to-back cycles:
  - The pipeline accepts one symbol per cycle.
  - Sustained rate above one symbol per two cycles, or with cw_ready low, overflows once space runs out.
- Simultaneous push (2 entries) and pop (1 entry): count changes by +1.
- Reset asserted mid-operation discards the stage-1 symbol and all FIFO contents immediately. No overflow pulse is generated.

## Test plan
- Reset, then sym_valid with I=+6, Q=-2, cw_ready=1 → carrier=1; cw_out=10 after edge t+1, then 01 after edge t+2; cw_valid low after the pop of the second entry.
- Idle gating: three zero symbols in IDLE → nothing pushed, carrier=0. Then in TRACK, symbols +2/+2, 0/0, 0/0, 0/0 (GAP=3) → entries 11,11, 11,11, 11,11 pushed; third zero dropped; carrier falls; unrel_cnt=2.
- Thresholds: symbols (-4,+4), (0,-8), (+7,-3) → codewords 00,10 / 11,00 / 10,01; unrel_cnt=2.
- Backpressure: cw_ready=0, two symbols fill FIFO_DEPTH=4; third symbol → overflow pulses one cycle, count stays 4, FIFO contents unchanged. Then cw_ready=1 → four entries drain in order.
- Simultaneous: count=3, symbol pushed while popping → push accepted (free=2), count=4, no overflow.
- Reset asserted with 3 entries queued and a symbol in stage 1 → cw_valid=0, carrier=0, unrel_cnt=0 immediately; no later push.
